// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never misalign.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = off[0];
      default:     is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_we,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane selection for both directions; funct3 arrives already normalised.
  always_comb begin
    ld_byte  = ld_rdata[{off, 3'b000} +: 8];
    ld_half  = ld_rdata[{off[1], 4'b0000} +: 16];
    st_we    = 4'b1111;
    st_wdata = st_data;
    ld_data  = ld_rdata;
    case (funct3)
      F3_B: begin
        st_we    = 4'b0001 << off;
        st_wdata = {4{st_data[7:0]}};
        ld_data  = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      end
      F3_BU: ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_H: begin
        st_we    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
        ld_data  = {{(DATA_W-16){ld_half[15]}}, ld_half};
      end
      F3_HU: ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, fixed memory read latency,
// busy stalls the pipeline while an access is in flight.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests skip memory and return
// a misalign pulse instead of an access.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  busy,
  output logic                  misalign
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic                  load_q, load_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [2:0]            cnt_q, cnt_d;

  logic [3:0]            st_we;
  logic [DATA_W-1:0]     st_wdata;
  logic [DATA_W-1:0]     ld_data;
  logic                  trap_hit;
  logic [2:0]            f3_norm;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3   (f3_q),
    .off      (addr_q[1:0]),
    .st_data  (wdata_q),
    .st_we    (st_we),
    .st_wdata (st_wdata),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = is_misaligned(f3_q, addr_q[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  // Fold unsupported funct3 codes onto a word access so later logic sees only legal codes.
  always_comb begin
    f3_norm = F3_W;
    if (req_load) begin
      if (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) f3_norm = req_funct3;
    end else begin
      if (req_funct3 inside {F3_B, F3_H, F3_W}) f3_norm = req_funct3;
    end
  end

  // Next-state, datapath capture and all outputs; reset forces outputs low in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    load_d     = load_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 4'b0000;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    busy       = 1'b0;
    misalign   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = f3_norm;
          load_d  = req_load;
          wdata_d = req_wdata;
          rdata_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (trap_hit) begin
          state_d = RESP;
        end else if (load_q) begin
          mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
          mem_re   = 1'b1;
          cnt_d    = LAT_LOAD;
          state_d  = WAIT;
        end else begin
          mem_addr  = {addr_q[DM_ADDRESS-1:2], 2'b00};
          mem_we    = st_we;
          mem_wdata = st_wdata;
          state_d   = RESP;
        end
      end
      WAIT: begin
        busy     = 1'b1;
        mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
        mem_re   = 1'b1;
        if (cnt_q == 3'd0) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        misalign   = trap_hit;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      req_ready  = 1'b0;
      mem_addr   = '0;
      mem_re     = 1'b0;
      mem_we     = 4'b0000;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      busy       = 1'b0;
      misalign   = 1'b0;
    end
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      load_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: instance A uses MEM_LATENCY=1, instance B
// MEM_LATENCY=3. Both share request fields and a backdoor word memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_load;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;

  logic        req_valid_a, req_ready_a, mem_re_a, resp_valid_a, busy_a, misalign_a;
  logic [8:0]  mem_addr_a;
  logic [3:0]  mem_we_a;
  logic [31:0] mem_wdata_a, mem_rdata_a, resp_rdata_a;

  logic        req_valid_b, req_ready_b, mem_re_b, resp_valid_b, busy_b, misalign_b;
  logic [8:0]  mem_addr_b;
  logic [3:0]  mem_we_b;
  logic [31:0] mem_wdata_b, mem_rdata_b, resp_rdata_b;

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr_a), .mem_re(mem_re_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
    .busy(busy_a), .misalign(misalign_a)
  );

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .busy(busy_b), .misalign(misalign_b)
  );

  // Word memory with a real read pipeline: data only shows after MEM_LATENCY cycles.
  localparam logic [31:0] GARBAGE = 32'h5A5A_C3C3;
  logic [31:0] mem_w [0:127];
  logic        pa_v;
  logic [31:0] pa_d;
  logic [2:0]  pb_v;
  logic [31:0] pb_d [0:2];

  always @(posedge clk) begin
    pa_v    <= mem_re_a;
    pa_d    <= mem_w[mem_addr_a[8:2]];
    pb_v    <= {pb_v[1:0], mem_re_b};
    pb_d[0] <= mem_w[mem_addr_b[8:2]];
    pb_d[1] <= pb_d[0];
    pb_d[2] <= pb_d[1];
  end
  assign mem_rdata_a = (pa_v === 1'b1)    ? pa_d    : GARBAGE;
  assign mem_rdata_b = (pb_v[2] === 1'b1) ? pb_d[2] : GARBAGE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model.
  function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3 == 3'd1 || f3 == 3'd5) return off[0];
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    return off != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (off * 8);
    case (f3)
      3'd0: return {{24{sh[7]}}, sh[7:0]};
      3'd4: return {24'h0, sh[7:0]};
      3'd1: return off[1] ? {{16{w[31]}}, w[31:16]} : {{16{w[15]}}, w[15:0]};
      3'd5: return off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_we(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0: return 4'(1 << off);
      3'd1: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'd1: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Response monitors: pop the scoreboard on every resp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && resp_valid_a === 1'b1) begin
      if (q_a.size() == 0) check("a_spurious_resp", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_rdata", resp_rdata_a, e.rdata);
        check("a_misalign", 32'(misalign_a), 32'(e.mis));
        check("a_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (reset === 1'b0 && resp_valid_b === 1'b1) begin
      if (q_b.size() == 0) check("b_spurious_resp", 1, 0);
      else begin
        e = q_b.pop_front();
        check("b_rdata", resp_rdata_b, e.rdata);
        check("b_misalign", 32'(misalign_b), 32'(e.mis));
        check("b_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (misalign_a === 1'b1 && resp_valid_a !== 1'b1) check("a_misalign_stray", 1, 0);
    if (misalign_b === 1'b1 && resp_valid_b !== 1'b1) check("b_misalign_stray", 1, 0);
  end

  // Drive one request, record expectations, then check the ISSUE-cycle memory outputs.
  // Called right after a negedge; returns in the ISSUE cycle.
  task automatic send(input bit b, input bit ld, input logic [2:0] f3, input logic [8:0] addr,
                      input logic [31:0] wd, input bit push, input bit keep, output int acc);
    exp_t        e;
    logic        trapped;
    logic [31:0] word;
    int          lat;
    trapped    = m_mis(f3, addr[1:0]);
    word       = mem_w[addr[8:2]];
    lat        = trapped ? 2 : (ld ? (b ? 5 : 3) : 2);
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      if ((b ? req_ready_b : req_ready_a) === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      check(b ? "b_accept_timeout" : "a_accept_timeout", 0, 1);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      return;
    end
    e.rdata = (trapped || !ld) ? 32'h0 : m_load(f3, addr[1:0], word);
    e.mis   = trapped;
    e.acc   = acc;
    e.lat   = lat;
    if (push) begin
      if (b) q_b.push_back(e); else q_a.push_back(e);
    end
    @(negedge clk);
    if (!keep) begin
      if (b) req_valid_b = 1'b0; else req_valid_a = 1'b0;
    end
    check(b ? "b_issue_busy" : "a_issue_busy", 32'(b ? busy_b : busy_a), 1);
    check(b ? "b_issue_re" : "a_issue_re", 32'(b ? mem_re_b : mem_re_a), 32'(ld && !trapped));
    check(b ? "b_issue_addr" : "a_issue_addr", 32'(b ? mem_addr_b : mem_addr_a),
          trapped ? 32'h0 : 32'(addr & 9'h1FC));
    check(b ? "b_issue_we" : "a_issue_we", 32'(b ? mem_we_b : mem_we_a),
          (ld || trapped) ? 32'h0 : 32'(m_we(f3, addr[1:0])));
    if (!ld && !trapped)
      check(b ? "b_issue_wdata" : "a_issue_wdata", b ? mem_wdata_b : mem_wdata_a, m_wd(f3, wd));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a !== 1'b0 || busy_b !== 1'b0 || q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int acc1, acc2, nbusy;
    reset       = 1'b1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_load    = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = '0;
    req_wdata   = '0;
    for (int i = 0; i < 128; i++) mem_w[i] = $urandom;

    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(req_ready_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_resp_a", 32'(resp_valid_a), 0);
    check("rst_re_a", 32'(mem_re_a), 0);
    check("rst_we_a", 32'(mem_we_a), 0);
    check("rst_addr_a", 32'(mem_addr_a), 0);
    check("rst_mis_a", 32'(misalign_a), 0);
    check("rst_busy_b", 32'(busy_b), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready_a", 32'(req_ready_a), 1);
    check("idle_ready_b", 32'(req_ready_b), 1);

    // SW and SB on the latency-1 instance.
    send(0, 0, F3_W, 9'h010, 32'hDEADBEEF, 1, 0, acc1);
    check("sw_we_const", 32'(mem_we_a), 32'h0000000F);
    check("sw_wdata_const", mem_wdata_a, 32'hDEADBEEF);
    wait_idle();
    send(0, 0, F3_B, 9'h013, 32'h000000A5, 1, 0, acc1);
    check("sb_we_const", 32'(mem_we_a), 32'h00000008);
    check("sb_addr_const", 32'(mem_addr_a), 32'h010);
    check("sb_wdata_const", mem_wdata_a, 32'hA5A5A5A5);
    wait_idle();

    // LB / LBU with latency 1.
    mem_w[8] = 32'h12348056;
    check("lb_model", m_load(F3_B, 2'd1, mem_w[8]), 32'hFFFFFF80);
    send(0, 1, F3_B, 9'h021, 32'h0, 1, 0, acc1);
    wait_idle();
    send(0, 1, F3_BU, 9'h021, 32'h0, 1, 0, acc1);
    wait_idle();

    // LH / LHU with latency 3; busy must span ISSUE + 3 WAIT + RESP.
    mem_w[8] = 32'h9ABC0000;
    send(1, 1, F3_H, 9'h022, 32'h0, 1, 0, acc1);
    nbusy = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_b !== 1'b1) break;
      nbusy++;
    end
    check("lh_busy_cycles", 32'(nbusy), 5);
    wait_idle();
    send(1, 1, F3_HU, 9'h022, 32'h0, 1, 0, acc1);
    wait_idle();

    // Back-to-back with req_valid held: second accept lands in the IDLE after RESP.
    send(0, 0, F3_W, 9'h030, 32'h11223344, 1, 1, acc1);
    send(0, 1, F3_W, 9'h030, 32'h0, 1, 0, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc1), 3);
    wait_idle();

    // Reset during WAIT aborts the load: no response, mem_re drops immediately.
    send(1, 1, F3_W, 9'h040, 32'h0, 0, 0, acc1);
    @(negedge clk);
    check("wait_re_before_rst", 32'(mem_re_b), 1);
    reset = 1'b1;
    #1;
    check("rst_wait_re_same_cycle", 32'(mem_re_b), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait_idle_ready", 32'(req_ready_b), 1);
    check("rst_wait_re", 32'(mem_re_b), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_wait_no_resp", 32'(resp_valid_b), 0);
    end

    // Misaligned LW at 0x006.
    mem_w[1] = 32'hCAFEF00D;
    send(0, 1, F3_W, 9'h006, 32'h0, 1, 0, acc1);
    wait_idle();

    // Random mix across both instances.
    for (int i = 0; i < 16; i++) begin
      bit          b, ld;
      logic [2:0]  f3;
      logic [2:0]  ld_codes [0:4];
      ld_codes = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
      b  = i[0];
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      send(b, ld, f3, 9'($urandom_range(0, 511)), $urandom, 1, 0, acc1);
      wait_idle();
    end

    check("q_a_empty", 32'(q_a.size()), 0);
    check("q_b_empty", 32'(q_b.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
